// File: rtl/shot_ctrl.sv
// Shot controller: turns a left-click on a fresh enemy cell into one req/ack shot,
// tracks shot/hit maps and counters. Define SHOT_TIMEOUT_EN to abort unanswered requests.
module shot_ctrl #(
  parameter int GRID_CELLS  = 10,
  parameter int SHIP_CELLS  = 17,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] enemy_cor,
  input  logic       cor_valid,
  input  logic       left,
  input  logic       turn_en,
  input  logic       new_game,
  output logic       shot_req,
  output logic [7:0] shot_cor,
  input  logic       shot_ack,
  input  logic       shot_hit,
  output logic       shot_done,
  output logic       last_hit,
  output logic       repeat_err,
  output logic [7:0] shot_cnt,
  output logic [7:0] hit_cnt,
  output logic       game_won,
  input  logic [7:0] query_cor,
  output logic       query_shot,
  output logic       query_hit,
  output logic       timeout
);

  localparam int IDX_W = (GRID_CELLS * GRID_CELLS > 1) ? $clog2(GRID_CELLS * GRID_CELLS) : 1;
  localparam int MAP_BITS = 1 << IDX_W;
  localparam logic [4:0] GRID_LIM = 5'(GRID_CELLS);
  localparam logic [7:0] SHIP_LIM = 8'(SHIP_CELLS);

  typedef enum logic [1:0] {IDLE, CHECK, REQ} state_t;

  function automatic logic in_grid(input logic [7:0] cor);
    return ({1'b0, cor[7:4]} < GRID_LIM) && ({1'b0, cor[3:0]} < GRID_LIM);
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [7:0] cor);
    logic [8:0] full;
    full = 9'(cor[7:4]) * 9'(GRID_CELLS) + 9'(cor[3:0]);
    return full[IDX_W-1:0];
  endfunction

  state_t state, next_state;
  logic left_q;
  logic click;
  logic ack_take;
  logic to_expire;
  logic [MAP_BITS-1:0] shot_map;
  logic [MAP_BITS-1:0] hit_map;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] q_idx;
  logic [7:0] hit_next;

  assign click    = left & ~left_q & cor_valid & turn_en & in_grid(enemy_cor);
  assign cur_idx  = cell_idx(shot_cor);
  assign q_idx    = cell_idx(query_cor);
  assign ack_take = (state == REQ) & shot_ack & ~new_game;
  assign hit_next = (shot_hit && hit_cnt != 8'hFF) ? hit_cnt + 8'd1 : hit_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (new_game) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (click) next_state = CHECK;
        CHECK:   next_state = shot_map[cur_idx] ? IDLE : REQ;
        REQ:     if (shot_ack || to_expire) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    shot_req = (state == REQ);
  end

  // new_game wipes the game but leaves the renderer lookup running
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q     <= 1'b0;
      shot_cor   <= 8'd0;
      shot_map   <= '0;
      hit_map    <= '0;
      shot_done  <= 1'b0;
      repeat_err <= 1'b0;
      last_hit   <= 1'b0;
      shot_cnt   <= 8'd0;
      hit_cnt    <= 8'd0;
      game_won   <= 1'b0;
      query_shot <= 1'b0;
      query_hit  <= 1'b0;
    end else begin
      query_shot <= in_grid(query_cor) & shot_map[q_idx];
      query_hit  <= in_grid(query_cor) & hit_map[q_idx];
      shot_done  <= 1'b0;
      repeat_err <= 1'b0;
      if (new_game) begin
        left_q   <= 1'b0;
        shot_cor <= 8'd0;
        shot_map <= '0;
        hit_map  <= '0;
        last_hit <= 1'b0;
        shot_cnt <= 8'd0;
        hit_cnt  <= 8'd0;
        game_won <= 1'b0;
      end else begin
        left_q <= left;
        if (state == IDLE && click) shot_cor <= enemy_cor;
        if (state == CHECK && shot_map[cur_idx]) repeat_err <= 1'b1;
        if (ack_take) begin
          shot_map[cur_idx] <= 1'b1;
          if (shot_hit) hit_map[cur_idx] <= 1'b1;
          last_hit  <= shot_hit;
          shot_cnt  <= (shot_cnt == 8'hFF) ? shot_cnt : shot_cnt + 8'd1;
          hit_cnt   <= hit_next;
          shot_done <= 1'b1;
          if (hit_next == SHIP_LIM) game_won <= 1'b1;
        end
      end
    end
  end

`ifdef SHOT_TIMEOUT_EN
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  logic [TO_W-1:0] to_cnt;
  logic to_pulse;

  assign to_expire = (state == REQ) && !shot_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign timeout   = to_pulse;

  // counter restarts whenever the machine is not waiting in REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= to_expire & ~new_game;
      if (state == REQ && next_state == REQ) to_cnt <= to_cnt + 1'b1;
      else                                   to_cnt <= '0;
    end
  end
`else
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_shot_ctrl.sv
// Randomized scoreboard bench for shot_ctrl; the timeout scenario runs when SHOT_TIMEOUT_EN is defined.
module tb_shot_ctrl;

  localparam int GRID = 10;
  localparam int SHIP = 17;
  localparam int ACK_TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] enemy_cor;
  logic cor_valid, left, turn_en, new_game;
  logic shot_req;
  logic [7:0] shot_cor;
  logic shot_ack, shot_hit;
  logic shot_done, last_hit, repeat_err;
  logic [7:0] shot_cnt, hit_cnt;
  logic game_won;
  logic [7:0] query_cor;
  logic query_shot, query_hit, timeout;

  typedef enum int {EV_REQ, EV_DONE, EV_REP, EV_TO} ev_t;
  typedef struct {
    ev_t kind;
    int cyc;
    logic [7:0] cor;
    logic hit;
    logic [7:0] scnt;
    logic [7:0] hcnt;
    logic won;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] held_cor = 8'd0;
  bit prev_req = 1'b0;

  // Reference model: plain per-cell arrays and counters
  bit m_shot[16][16];
  bit m_hit[16][16];
  int m_scnt, m_hcnt;
  bit m_won;

  shot_ctrl #(.GRID_CELLS(GRID), .SHIP_CELLS(SHIP), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .enemy_cor(enemy_cor), .cor_valid(cor_valid), .left(left),
    .turn_en(turn_en), .new_game(new_game), .shot_req(shot_req), .shot_cor(shot_cor),
    .shot_ack(shot_ack), .shot_hit(shot_hit), .shot_done(shot_done), .last_hit(last_hit),
    .repeat_err(repeat_err), .shot_cnt(shot_cnt), .hit_cnt(hit_cnt), .game_won(game_won),
    .query_cor(query_cor), .query_shot(query_shot), .query_hit(query_hit), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void modelClear();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        m_shot[x][y] = 1'b0;
        m_hit[x][y]  = 1'b0;
      end
    m_scnt = 0;
    m_hcnt = 0;
    m_won  = 1'b0;
  endfunction

  function automatic void push(input ev_t k, input int c, input logic [7:0] cor);
    exp_t e;
    e.kind = k; e.cyc = c; e.cor = cor; e.hit = 1'b0;
    e.scnt = 8'(m_scnt); e.hcnt = 8'(m_hcnt); e.won = m_won;
    sb.push_back(e);
  endfunction

  task automatic take(input ev_t k);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("unexpected_event", k, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      checkOutput("event_kind", k, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (k == EV_REQ) begin
        checkOutput("shot_cor", shot_cor, e.cor);
        held_cor = e.cor;
      end
      if (k == EV_DONE) begin
        checkOutput("last_hit", last_hit, e.hit);
        checkOutput("shot_cnt", shot_cnt, e.scnt);
        checkOutput("hit_cnt", hit_cnt, e.hcnt);
        checkOutput("game_won", game_won, e.won);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (shot_req && !prev_req) take(EV_REQ);
        else if (shot_req) checkOutput("shot_cor_stable", shot_cor, held_cor);
        if (shot_done)  take(EV_DONE);
        if (repeat_err) take(EV_REP);
        if (timeout)    take(EV_TO);
        prev_req = shot_req;
      end
    end
  end

  // Issue one click; res = 0 ignored, 1 repeat, 2 request. k = cycle count at the drive edge.
  task automatic applyStimulus(input logic [7:0] cor, input bit tv, input bit cv, input bit drop_turn,
                               output int res, output int k);
    bit valid;
    int x, y;
    x = int'(cor[7:4]);
    y = int'(cor[3:0]);
    valid = tv && cv && x < GRID && y < GRID;
    @(negedge clk);
    enemy_cor = cor; cor_valid = cv; turn_en = tv; left = 1'b1;
    k = cyc;
    res = 0;
    if (valid) begin
      if (m_shot[x][y]) begin
        res = 1;
        push(EV_REP, k + 2, cor);
      end else begin
        res = 2;
        push(EV_REQ, k + 2, cor);
      end
    end
    @(negedge clk);
    left = 1'b0;
    if (drop_turn) turn_en = 1'b0;
  endtask

  task automatic ackShot(input logic [7:0] cor, input bit hit, input int delay, input bit with_ng);
    exp_t e;
    int x, y;
    x = int'(cor[7:4]);
    y = int'(cor[3:0]);
    for (int i = 0; i < 8 && !shot_req; i++) @(negedge clk);
    if (!shot_req) begin
      checkOutput("req_wait", 0, 1);
      return;
    end
    repeat (delay) @(negedge clk);
    shot_ack = 1'b1; shot_hit = hit; new_game = with_ng;
    if (with_ng) begin
      modelClear();
    end else begin
      m_shot[x][y] = 1'b1;
      if (hit) m_hit[x][y] = 1'b1;
      if (m_scnt < 255) m_scnt++;
      if (hit && m_hcnt < 255) m_hcnt++;
      if (m_hcnt == SHIP) m_won = 1'b1;
      e.kind = EV_DONE; e.cyc = cyc + 1; e.cor = cor; e.hit = hit;
      e.scnt = 8'(m_scnt); e.hcnt = 8'(m_hcnt); e.won = m_won;
      sb.push_back(e);
    end
    @(negedge clk);
    shot_ack = 1'b0; shot_hit = 1'b0; new_game = 1'b0;
    if (with_ng) checkOutput("ng_abort_req", shot_req, 0);
  endtask

  task automatic checkQuery(input logic [7:0] cor);
    bit ok;
    ok = int'(cor[7:4]) < GRID && int'(cor[3:0]) < GRID;
    @(negedge clk);
    query_cor = cor;
    @(negedge clk);
    checkOutput("query_shot", query_shot, ok && m_shot[cor[7:4]][cor[3:0]]);
    checkOutput("query_hit", query_hit, ok && m_hit[cor[7:4]][cor[3:0]]);
  endtask

  task automatic randomShot(output bit was_new);
    logic [7:0] cor;
    int res, k;
    cor = {4'($urandom_range(0, GRID - 1)), 4'($urandom_range(0, GRID - 1))};
    applyStimulus(cor, 1'b1, 1'b1, $urandom_range(0, 3) == 0, res, k);
    was_new = (res == 2);
    if (res == 2) ackShot(cor, $urandom_range(0, 2) != 0, $urandom_range(0, 3), 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int res, k, iter, extra;
    bit was_new;
    logic [7:0] cor;
    rst = 1'b1; enemy_cor = 8'd0; cor_valid = 1'b0; left = 1'b0; turn_en = 1'b0;
    new_game = 1'b0; shot_ack = 1'b0; shot_hit = 1'b0; query_cor = 8'd0;
    modelClear();
    repeat (3) @(negedge clk);
    checkOutput("rst_shot_req", shot_req, 0);
    checkOutput("rst_shot_cor", shot_cor, 0);
    checkOutput("rst_shot_done", shot_done, 0);
    checkOutput("rst_repeat_err", repeat_err, 0);
    checkOutput("rst_counts", {shot_cnt, hit_cnt}, 0);
    checkOutput("rst_flags", {last_hit, game_won, query_shot, query_hit, timeout}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] first shot on 8'h34");
    applyStimulus(8'h34, 1'b1, 1'b1, 1'b0, res, k);
    ackShot(8'h34, 1'b1, 0, 1'b0);
    repeat (2) @(negedge clk);
    checkQuery(8'h34);

    $display("[TB] repeat click and ignored clicks");
    applyStimulus(8'h34, 1'b1, 1'b1, 1'b0, res, k);
    repeat (3) @(negedge clk);
    checkOutput("cnt_after_repeat", shot_cnt, 1);
    applyStimulus(8'hA2, 1'b1, 1'b1, 1'b0, res, k);
    applyStimulus(8'h3B, 1'b1, 1'b1, 1'b0, res, k);
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, res, k);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, res, k);
    @(negedge clk);
    enemy_cor = 8'h56; turn_en = 1'b1; cor_valid = 1'b0; left = 1'b1;
    @(negedge clk);
    cor_valid = 1'b1;
    repeat (2) @(negedge clk);
    left = 1'b0;
    shot_ack = 1'b1; shot_hit = 1'b1;
    @(negedge clk);
    shot_ack = 1'b0; shot_hit = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("cnt_after_ignored", shot_cnt, 1);

    $display("[TB] random play until the fleet is sunk");
    iter = 0;
    while (m_hcnt < SHIP && iter < 600) begin
      iter++;
      if ($urandom_range(0, 7) == 0) begin
        cor = 8'($urandom_range(0, 255));
        applyStimulus(cor, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0, res, k);
        if (res == 2) ackShot(cor, 1'b1, 1, 1'b0);
        repeat (3) @(negedge clk);
      end else begin
        randomShot(was_new);
      end
    end
    checkOutput("hit_cnt_ship", hit_cnt, SHIP);
    checkOutput("game_won_set", game_won, 1);
    for (int i = 0; i < 8; i++) checkQuery(8'($urandom_range(0, 255)));

    extra = 0;
    for (int i = 0; i < 100 && extra < 2; i++) begin
      randomShot(was_new);
      if (was_new) extra++;
    end
    checkOutput("won_still_set", game_won, 1);
    checkQuery(8'h34);

    $display("[TB] new_game clears the game");
    @(negedge clk);
    new_game = 1'b1;
    modelClear();
    @(negedge clk);
    new_game = 1'b0;
    checkOutput("ng_counts", {shot_cnt, hit_cnt}, 0);
    checkOutput("ng_flags", {game_won, last_hit}, 0);
    checkQuery(8'h34);

    $display("[TB] new_game collides with ack");
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b0, res, k);
    ackShot(8'h77, 1'b1, 1, 1'b1);
    repeat (2) @(negedge clk);
    checkQuery(8'h77);
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b0, res, k);
    checkOutput("reclick_after_abort", res, 2);
    ackShot(8'h77, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("cnt_after_reclick", shot_cnt, 1);

`ifdef SHOT_TIMEOUT_EN
    $display("[TB] ack timeout");
    applyStimulus(8'h12, 1'b1, 1'b1, 1'b0, res, k);
    push(EV_TO, k + 2 + ACK_TO, 8'h12);
    repeat (ACK_TO + 3) @(negedge clk);
    checkOutput("to_req_low", shot_req, 0);
    checkOutput("to_cnt_same", shot_cnt, 1);
    applyStimulus(8'h12, 1'b1, 1'b1, 1'b0, res, k);
    checkOutput("to_reclick", res, 2);
    ackShot(8'h12, 1'b1, 0, 1'b0);
`else
    $display("[TB] request waits without timeout");
    applyStimulus(8'h12, 1'b1, 1'b1, 1'b0, res, k);
    repeat (ACK_TO + 6) @(negedge clk);
    checkOutput("no_to_req_high", shot_req, 1);
    checkOutput("no_to_pulse", timeout, 0);
    ackShot(8'h12, 1'b1, 0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_ctrl.md
Name: shot_ctrl

Overview:
- Consumes the registered enemy-board cell coordinate and mouse button from the mouse/player controller.
- Converts a left-click on a valid enemy cell into a single shot request to game logic over a req/ack handshake.
- Rejects repeat shots, keeps shot/hit maps and counters, and flags the win.
- Offers a 1-cycle-latency map lookup port for the enemy-board renderer.

Parameters:
- GRID_CELLS, 10, cells per board side; legal x,y are 0..GRID_CELLS-1 (max 16).
- SHIP_CELLS, 17, total enemy ship cells; hit_cnt reaching this value means the game is won.
- ACK_TIMEOUT, 1023, cycles to wait for shot_ack before aborting (only with SHOT_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enemy_cor  in  8  hovered enemy cell {x[3:0],y[3:0]}
- cor_valid  in  1  cursor is inside the enemy grid
- left  in  1  left mouse button level
- turn_en  in  1  player's turn; clicks are ignored when low
- new_game  in  1  pulse; clears maps and counters
- shot_req  out  1  shot request, held until ack
- shot_cor  out  8  coordinate of requested shot, stable while shot_req=1
- shot_ack  in  1  game logic accepts the shot; shot_hit is valid this cycle
- shot_hit  in  1  result of the shot (1 = hit)
- shot_done  out  1  1-cycle pulse after a completed shot
- last_hit  out  1  result of last completed shot
- repeat_err  out  1  1-cycle pulse: clicked an already-shot cell
- shot_cnt  out  8  completed shots, saturating at 255
- hit_cnt  out  8  completed hits, saturating at 255
- game_won  out  1  level; set when hit_cnt == SHIP_CELLS
- query_cor  in  8  renderer lookup coordinate
- query_shot  out  1  cell at query_cor was shot (registered, 1-cycle latency)
- query_hit  out  1  cell at query_cor was hit (registered, 1-cycle latency)
- timeout  out  1  1-cycle pulse on ack timeout (0 when feature disabled)

Behaviour:
- Reset (rst=1 at clk edge):
  - All outputs 0; state IDLE.
  - shot and hit maps (GRID_CELLS² bits each) cleared; left_q = 0.
- Click detection:
  - left_q registers left every cycle.
  - click = left & ~left_q & cor_valid & turn_en & (x < GRID_CELLS) & (y < GRID_CELLS).
  - A click outside IDLE is dropped, not queued.
- Cell index: idx = x*GRID_CELLS + y.
- State machine:
  - IDLE: on click, latch enemy_cor into shot_cor, go to CHECK.
  - CHECK (1 cycle):
    - If shot_map[idx]=1: pulse repeat_err next cycle, return to IDLE.
    - Otherwise go to REQ.
  - REQ:
    - shot_req=1 and shot_cor held stable.
    - On shot_ack=1, in the same edge:
      - set shot_map[idx]; set hit_map[idx] if shot_hit;
      - last_hit <= shot_hit; shot_cnt += 1; hit_cnt += shot_hit (both saturating);
      - shot_req <= 0; shot_done <= 1; go to IDLE.
    - Click-to-shot_req latency = 2 cycles.
- shot_ack while not in REQ is ignored.
- game_won is set registered when hit_cnt becomes SHIP_CELLS, stays high until new_game or rst, and does not block further shots.
- new_game has priority over every other event:
  - same effect as reset except query_* keep updating;
  - aborts REQ (shot_req=0 next cycle), with no shot_done even if shot_ack arrives in the same cycle.
- turn_en dropping during CHECK or REQ does not abort the shot in progress.
- Query port: an out-of-range query_cor returns 0/0.

Optional Feature:
- SHOT_TIMEOUT_EN defined:
  - A cycle counter runs in REQ.
  - If ACK_TIMEOUT cycles elapse with no shot_ack: shot_req <= 0, timeout pulses 1 cycle, go to IDLE.
  - Maps and counters are unchanged; the counter resets on each REQ entry.
- Not defined: REQ waits indefinitely; timeout is tied to 0; no counter logic.

Test Plan:
- rst, then turn_en=1, cor_valid=1, enemy_cor=8'h34, left 0→1 → shot_req=1 two cycles after the edge with shot_cor=8'h34; ack with shot_hit=1 → shot_done pulse, shot_cnt=1, hit_cnt=1, last_hit=1; query_cor=8'h34 → query_shot=1, query_hit=1 one cycle later.
- Repeat the click on 8'h34 → repeat_err one pulse, no shot_req, shot_cnt stays 1.
- Click with enemy_cor=8'hA2 (x=10), or turn_en=0, or cor_valid=0, or left held high across cycles → no shot_req, no repeat_err.
- 17 distinct cells, each acked with shot_hit=1 → hit_cnt=17, game_won=1; then new_game → game_won=0, counters 0, query_shot for 8'h34 = 0.
- new_game asserted in the same cycle as shot_ack in REQ → no shot_done, map bit stays 0, shot_req=0 next cycle.
- SHOT_TIMEOUT_EN, ACK_TIMEOUT=8, no ack → shot_req drops after 8 REQ cycles, timeout pulses once, shot_cnt unchanged; the same cell can be clicked again without repeat_err.
